// File: rtl/d_reg_pipe.sv
// d_reg_pipe: WIDTH-bit, DEPTH-stage registered delay line with stall, flush,
// per-stage valid and occupancy count. Define D_REG_PIPE_PARITY_EN for parity.
module d_reg_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int OCCW  = $clog2(DEPTH + 1)
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
`ifdef D_REG_PIPE_PARITY_EN
  input  logic             DP,
  output logic             PERR,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] notQ,
  output logic             QV,
  output logic [OCCW-1:0]  OCC
);

  logic [WIDTH-1:0] dataQ [DEPTH];
  logic [WIDTH-1:0] dataD [DEPTH];
  logic [DEPTH-1:0] validQ, validD;
  logic [OCCW-1:0]  occQ;
`ifdef D_REG_PIPE_PARITY_EN
  logic [DEPTH-1:0] parQ, parD;
  logic             perrQ;
`endif

  // Flush only drops valid bits; data and parity keep their contents.
  always_comb begin
    dataD  = dataQ;
    validD = validQ;
`ifdef D_REG_PIPE_PARITY_EN
    parD   = parQ;
`endif
    if (FLUSH) begin
      validD = '0;
    end else if (CE) begin
      dataD[0]  = D;
      validD[0] = DV;
`ifdef D_REG_PIPE_PARITY_EN
      parD[0]   = DP;
`endif
      for (int i = 1; i < DEPTH; i++) begin
        dataD[i]  = dataQ[i-1];
        validD[i] = validQ[i-1];
`ifdef D_REG_PIPE_PARITY_EN
        parD[i]   = parQ[i-1];
`endif
      end
    end
  end

  // Occupancy and parity error derive from next-state so they track the stages exactly.
  always_ff @(posedge C) begin
    if (R) begin
      for (int i = 0; i < DEPTH; i++) begin
        dataQ[i] <= '0;
      end
      validQ <= '0;
      occQ   <= '0;
`ifdef D_REG_PIPE_PARITY_EN
      parQ   <= '0;
      perrQ  <= 1'b0;
`endif
    end else begin
      dataQ  <= dataD;
      validQ <= validD;
      occQ   <= OCCW'($countones(validD));
`ifdef D_REG_PIPE_PARITY_EN
      parQ   <= parD;
      perrQ  <= validD[DEPTH-1] & ((^dataD[DEPTH-1]) ^ parD[DEPTH-1]);
`endif
    end
  end

  assign Q    = dataQ[DEPTH-1];
  assign notQ = ~dataQ[DEPTH-1];
  assign QV   = validQ[DEPTH-1];
  assign OCC  = occQ;
`ifdef D_REG_PIPE_PARITY_EN
  assign PERR = perrQ;
`endif

endmodule

// File: tb/tb_d_reg_pipe.sv
// Self-checking bench for d_reg_pipe against a queue-based delay-line model.
// Parity scenario is built only when D_REG_PIPE_PARITY_EN is defined.
module tb_d_reg_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OCCW  = $clog2(DEPTH + 1);

  logic             C = 1'b0;
  logic             R, CE, FLUSH, DV, dpIn;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q, notQ;
  logic             QV;
  logic [OCCW-1:0]  OCC;
`ifdef D_REG_PIPE_PARITY_EN
  logic             PERR;
`endif

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] mData [$];
  bit               mValid [$];
  bit               mPar [$];
  logic [WIDTH-1:0] expQ;
  bit               expQV;
  int               expOcc;
  bit               expPerr;

  d_reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OCCW(OCCW)) dut (
    .C(C), .R(R), .CE(CE), .FLUSH(FLUSH), .D(D), .DV(DV),
`ifdef D_REG_PIPE_PARITY_EN
    .DP(dpIn), .PERR(PERR),
`endif
    .Q(Q), .notQ(notQ), .QV(QV), .OCC(OCC)
  );

  always #5 C = ~C;

  // Advance one edge: model a pipe as a fixed-length queue, newest at the front.
  task automatic tick();
    logic [WIDTH-1:0] dropD;
    bit dropB;
    @(posedge C);
    if (R) begin
      for (int i = 0; i < DEPTH; i++) begin
        mData[i] = '0; mValid[i] = 0; mPar[i] = 0;
      end
    end else if (FLUSH) begin
      for (int i = 0; i < DEPTH; i++) mValid[i] = 0;
    end else if (CE) begin
      mData.push_front(D); mValid.push_front(DV); mPar.push_front(dpIn);
      dropD = mData.pop_back(); dropB = mValid.pop_back(); dropB = mPar.pop_back();
    end
    #1;
    expQ   = mData[DEPTH-1];
    expQV  = mValid[DEPTH-1];
    expOcc = 0;
    foreach (mValid[i]) if (mValid[i]) expOcc++;
    expPerr = expQV & ((^expQ) ^ mPar[DEPTH-1]);
  endtask

  task automatic test_reset();
    R = 1; CE = 1; FLUSH = 0; D = 8'hA5; DV = 1; dpIn = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (Q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", Q); end
      checks++; if (notQ !== 8'hFF) begin failures++; $display("FAIL reset_notq got=%h exp=FF", notQ); end
      checks++; if (QV !== 1'b0) begin failures++; $display("FAIL reset_qv got=%b exp=0", QV); end
      checks++; if (OCC !== '0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", OCC); end
    end
  endtask

  task automatic test_streaming();
    R = 0; CE = 1; FLUSH = 0; DV = 1;
    for (int k = 1; k <= 8; k++) begin
      D = WIDTH'(k);
      tick();
      if (k >= DEPTH) begin
        checks++; if (Q !== WIDTH'(k - DEPTH + 1) || QV !== 1'b1)
          begin failures++; $display("FAIL stream_q edge=%0d got=%h/%b exp=%h/1", k, Q, QV, WIDTH'(k - DEPTH + 1)); end
        checks++; if (OCC !== OCCW'(DEPTH)) begin failures++; $display("FAIL stream_occ edge=%0d got=%0d exp=%0d", k, OCC, DEPTH); end
      end else begin
        checks++; if (QV !== 1'b0) begin failures++; $display("FAIL stream_qv edge=%0d got=%b exp=0", k, QV); end
        checks++; if (OCC !== OCCW'(k)) begin failures++; $display("FAIL stream_occ edge=%0d got=%0d exp=%0d", k, OCC, k); end
      end
      checks++; if (notQ !== ~expQ) begin failures++; $display("FAIL stream_notq edge=%0d got=%h exp=%h", k, notQ, ~expQ); end
    end
  endtask

  task automatic test_stall();
    int first10, first11;
    logic [WIDTH-1:0] prevQ;
    logic [OCCW-1:0] prevOcc;
    logic prevQV;
    first10 = 0; first11 = 0;
    FLUSH = 1; tick(); FLUSH = 0;
    for (int e = 1; e <= 12; e++) begin
      CE = (e >= 3 && e <= 5) ? 1'b0 : 1'b1;
      DV = (e <= 2);
      D  = (e == 1) ? 8'h10 : (e == 2) ? 8'h11 : 8'hEE;
      prevQ = Q; prevQV = QV; prevOcc = OCC;
      tick();
      if (!CE) begin
        checks++; if (Q !== prevQ || QV !== prevQV || OCC !== prevOcc)
          begin failures++; $display("FAIL stall_frozen edge=%0d got=%h/%b/%0d exp=%h/%b/%0d", e, Q, QV, OCC, prevQ, prevQV, prevOcc); end
      end
      checks++; if (Q !== expQ || QV !== expQV || OCC !== OCCW'(expOcc))
        begin failures++; $display("FAIL stall_model edge=%0d got=%h/%b/%0d exp=%h/%b/%0d", e, Q, QV, OCC, expQ, expQV, expOcc); end
      if (QV === 1'b1 && Q === 8'h10 && first10 == 0) first10 = e;
      if (QV === 1'b1 && Q === 8'h11 && first11 == 0) first11 = e;
    end
    checks++; if (first10 != DEPTH + 3) begin failures++; $display("FAIL stall_latency10 got=%0d exp=%0d", first10, DEPTH + 3); end
    checks++; if (first11 != DEPTH + 4) begin failures++; $display("FAIL stall_latency11 got=%0d exp=%0d", first11, DEPTH + 4); end
  endtask

  task automatic test_bubble_flush();
    bit qvSeq [3];
    logic [WIDTH-1:0] heldQ;
    qvSeq = '{1, 0, 1};
    CE = 1; FLUSH = 1; tick(); FLUSH = 0;
    for (int e = 1; e <= 6; e++) begin
      DV = (e <= 3) ? qvSeq[e-1] : 1'b0;
      D  = WIDTH'(8'h40 + e);
      tick();
      if (e == 3) begin
        checks++; if (OCC !== OCCW'(2)) begin failures++; $display("FAIL bubble_occ got=%0d exp=2", OCC); end
      end
      if (e >= 4) begin
        checks++; if (QV !== qvSeq[e-4]) begin failures++; $display("FAIL bubble_qv edge=%0d got=%b exp=%b", e, QV, qvSeq[e-4]); end
      end
    end
    heldQ = Q;
    FLUSH = 1; CE = 1; DV = 1; D = 8'h77;
    tick();
    FLUSH = 0;
    checks++; if (QV !== 1'b0 || OCC !== '0) begin failures++; $display("FAIL flush_clear got=%b/%0d exp=0/0", QV, OCC); end
    checks++; if (Q !== heldQ) begin failures++; $display("FAIL flush_qhold got=%h exp=%h", Q, heldQ); end
  endtask

  task automatic test_reset_mid();
    CE = 1; FLUSH = 1; tick(); FLUSH = 0;
    DV = 1;
    for (int e = 0; e < 3; e++) begin D = WIDTH'(8'hC0 + e); tick(); end
    checks++; if (OCC !== OCCW'(3)) begin failures++; $display("FAIL midreset_pre_occ got=%0d exp=3", OCC); end
    R = 1; D = 8'hDD; DV = 1;
    tick();
    R = 0; DV = 0;
    checks++; if (OCC !== '0 || Q !== '0) begin failures++; $display("FAIL midreset_clear got=%0d/%h exp=0/00", OCC, Q); end
    for (int e = 0; e < DEPTH; e++) begin
      tick();
      checks++; if (QV !== 1'b0 || OCC !== '0) begin failures++; $display("FAIL midreset_empty edge=%0d got=%b/%0d exp=0/0", e, QV, OCC); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      R     = ($urandom_range(0, 39) == 0);
      FLUSH = ($urandom_range(0, 9) == 0);
      CE    = ($urandom_range(0, 3) != 0);
      DV    = ($urandom_range(0, 2) != 0);
      D     = WIDTH'($urandom);
      dpIn  = $urandom_range(0, 1) == 1;
      tick();
      checks++; if (Q !== expQ || notQ !== ~expQ || QV !== expQV || OCC !== OCCW'(expOcc))
        begin failures++; $display("FAIL rand cyc=%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d", n, Q, notQ, QV, OCC, expQ, ~expQ, expQV, expOcc); end
`ifdef D_REG_PIPE_PARITY_EN
      checks++; if (PERR !== expPerr) begin failures++; $display("FAIL rand_perr cyc=%0d got=%b exp=%b", n, PERR, expPerr); end
`endif
    end
    R = 0; FLUSH = 0;
  endtask

`ifdef D_REG_PIPE_PARITY_EN
  task automatic test_parity();
    CE = 1; FLUSH = 1; tick(); FLUSH = 0;
    for (int e = 1; e <= DEPTH + 1; e++) begin
      DV = (e <= 2); dpIn = 0;
      D  = (e == 1) ? 8'h03 : 8'h01;
      tick();
      if (e == DEPTH) begin
        checks++; if (Q !== 8'h03 || PERR !== 1'b0) begin failures++; $display("FAIL parity_ok got=%h/%b exp=03/0", Q, PERR); end
      end
      if (e == DEPTH + 1) begin
        checks++; if (Q !== 8'h01 || PERR !== 1'b1) begin failures++; $display("FAIL parity_err got=%h/%b exp=01/1", Q, PERR); end
      end
    end
    FLUSH = 1; tick(); FLUSH = 0;
    checks++; if (PERR !== 1'b0) begin failures++; $display("FAIL parity_flush got=%b exp=0", PERR); end
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mData.push_back('0); mValid.push_back(0); mPar.push_back(0);
    end
    R = 1; CE = 0; FLUSH = 0; D = '0; DV = 0; dpIn = 0;
    @(negedge C);
    test_reset();
    test_streaming();
    test_stall();
    test_bubble_flush();
    test_reset_mid();
`ifdef D_REG_PIPE_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
